// File: rtl/elastic_fifo.sv
// Valid/ready elastic buffer: registered output stage backed by a circular store of DEPTH-1 words.
// up_ready is a register derived from the next occupancy, so down_ready never reaches it combinationally.
module elastic_fifo #(
    parameter int unsigned D_WIDTH  = 6,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned AF_LEVEL = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       up_valid,
    output logic                       up_ready,
    input  logic [D_WIDTH-1:0]         up_data,
    output logic                       down_valid,
    input  logic                       down_ready,
    output logic [D_WIDTH-1:0]         down_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       almost_full
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned SD = DEPTH - 1;
    localparam int unsigned PW = (SD > 1) ? $clog2(SD) : 1;
    localparam logic [PW-1:0] PTR_LAST = PW'(SD - 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C     = CW'(AF_LEVEL);

    logic [D_WIDTH-1:0] r_mem [SD];
    logic [PW-1:0]      r_wr_ptr, r_rd_ptr;
    logic               r_down_valid;
    logic [D_WIDTH-1:0] r_down_data;
    logic [CW-1:0]      r_count;
    logic               r_up_ready;
    logic               r_almost_full;

    logic               w_push, w_pop, w_store_empty, w_refill, w_store_wr;
    logic [PW-1:0]      w_wr_ptr_d, w_rd_ptr_d;
    logic               w_down_valid_d;
    logic [D_WIDTH-1:0] w_down_data_d;
    logic [CW-1:0]      w_count_d;
    logic               w_up_ready_d, w_almost_full_d;

    always_comb begin
        w_push         = up_valid & r_up_ready;
        w_pop          = r_down_valid & down_ready;
        // count includes the output register, so the store holds count - down_valid words
        w_store_empty  = (r_count == CW'(r_down_valid));
        w_refill       = !r_down_valid || w_pop;
        w_down_valid_d = r_down_valid;
        w_down_data_d  = r_down_data;
        w_rd_ptr_d     = r_rd_ptr;
        w_wr_ptr_d     = r_wr_ptr;
        w_store_wr     = 1'b0;

        if (w_refill) begin
            if (!w_store_empty) begin
                w_down_valid_d = 1'b1;
                w_down_data_d  = r_mem[r_rd_ptr];
                w_rd_ptr_d     = (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + PW'(1);
                w_store_wr     = w_push;
            end else if (w_push) begin
                w_down_valid_d = 1'b1;
                w_down_data_d  = up_data;
            end else begin
                w_down_valid_d = 1'b0;
            end
        end else begin
            w_store_wr = w_push;
        end

        if (w_store_wr) begin
            w_wr_ptr_d = (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + PW'(1);
        end

        w_count_d       = r_count + CW'(w_push) - CW'(w_pop);
        w_up_ready_d    = (w_count_d < DEPTH_C);
        w_almost_full_d = (w_count_d >= AF_C);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_down_valid  <= 1'b0;
            r_down_data   <= '0;
            r_count       <= '0;
            r_up_ready    <= 1'b0;
            r_almost_full <= 1'b0;
        end else begin
            r_wr_ptr      <= w_wr_ptr_d;
            r_rd_ptr      <= w_rd_ptr_d;
            r_down_valid  <= w_down_valid_d;
            r_down_data   <= w_down_data_d;
            r_count       <= w_count_d;
            r_up_ready    <= w_up_ready_d;
            r_almost_full <= w_almost_full_d;
        end
    end

    // Storage is not reset; the pointers and count define which entries are live.
    always_ff @(posedge clk) begin
        if (w_store_wr) begin
            r_mem[r_wr_ptr] <= up_data;
        end
    end

    assign up_ready    = r_up_ready;
    assign down_valid  = r_down_valid;
    assign down_data   = r_down_data;
    assign count       = r_count;
    assign almost_full = r_almost_full;

endmodule

// File: tb/tb_elastic_fifo.sv
// Bench for elastic_fifo: directed scenarios plus randomized valid/ready traffic
// checked against a queue-based reference model of the buffer contents.
module tb_elastic_fifo;

    localparam int unsigned D_WIDTH  = 6;
    localparam int unsigned DEPTH    = 4;
    localparam int unsigned AF_LEVEL = 3;
    localparam int unsigned CW       = $clog2(DEPTH + 1);

    logic               clk;
    logic               rst;
    logic               up_valid;
    logic               up_ready;
    logic [D_WIDTH-1:0] up_data;
    logic               down_valid;
    logic               down_ready;
    logic [D_WIDTH-1:0] down_data;
    logic [CW-1:0]      count;
    logic               almost_full;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: queue of held words (head = word on down_data) and registered up_ready.
    logic [D_WIDTH-1:0] m_q [$];
    logic               m_ur;

    elastic_fifo #(
        .D_WIDTH (D_WIDTH),
        .DEPTH   (DEPTH),
        .AF_LEVEL(AF_LEVEL)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .up_valid   (up_valid),
        .up_ready   (up_ready),
        .up_data    (up_data),
        .down_valid (down_valid),
        .down_ready (down_ready),
        .down_data  (down_data),
        .count      (count),
        .almost_full(almost_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, update the model from the inputs seen there, return at negedge.
    task automatic tick();
        logic push, pop;
        @(posedge clk);
        if (!rst) begin
            m_q.delete();
            m_ur = 1'b0;
        end else begin
            push = up_valid && m_ur;
            pop  = (m_q.size() > 0) && down_ready;
            if (pop) void'(m_q.pop_front());
            if (push) m_q.push_back(up_data);
            m_ur = (m_q.size() < DEPTH);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0; up_valid = 1'b0; down_ready = 1'b0; up_data = '0;
        m_q.delete(); m_ur = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({down_valid, count, almost_full, up_ready} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: dv=%b cnt=%0d af=%b ur=%b, required all 0",
                     down_valid, count, almost_full, up_ready);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if (up_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release_ur: got %b, required 0", up_ready);
        end
        tick();
        n_cmp++;
        if (up_ready !== 1'b1 || down_valid !== 1'b0 || count !== 0) begin
            n_fail++;
            $display("FAIL first_edge: ur=%b dv=%b cnt=%0d, required ur=1 dv=0 cnt=0",
                     up_ready, down_valid, count);
        end
    endtask

    task automatic test_stream();
        down_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            up_valid = 1'b1;
            up_data  = D_WIDTH'(i);
            tick();
            n_cmp++;
            if (down_valid !== 1'b1 || down_data !== D_WIDTH'(i) || count !== 1 ||
                up_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL stream[%0d]: dv=%b dd=%h cnt=%0d ur=%b, required 1 %h 1 1",
                         i, down_valid, down_data, count, up_ready, i);
            end
        end
        up_valid = 1'b0;
        tick();
        n_cmp++;
        if (down_valid !== 1'b0 || count !== 0) begin
            n_fail++;
            $display("FAIL stream_end: dv=%b cnt=%0d, required 0 0", down_valid, count);
        end
    endtask

    task automatic test_fill_stall();
        logic [D_WIDTH-1:0] w [4] = '{6'h2A, 6'h15, 6'h3F, 6'h00};
        down_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            up_valid = 1'b1;
            up_data  = w[k];
            tick();
            n_cmp++;
            if (count !== CW'(k + 1) || almost_full !== (k + 1 >= AF_LEVEL) ||
                up_ready !== (k < 3) || down_valid !== 1'b1 || down_data !== 6'h2A) begin
                n_fail++;
                $display("FAIL fill[%0d]: cnt=%0d af=%b ur=%b dv=%b dd=%h", k, count,
                         almost_full, up_ready, down_valid, down_data);
            end
        end
        up_data = 6'h11;
        repeat (2) begin
            tick();
            n_cmp++;
            if (count !== 4 || up_ready !== 1'b0 || down_data !== 6'h2A || almost_full !== 1'b1) begin
                n_fail++;
                $display("FAIL stall_hold: cnt=%0d ur=%b dd=%h af=%b, required 4 0 2a 1",
                         count, up_ready, down_data, almost_full);
            end
        end
    endtask

    task automatic test_drain();
        logic [D_WIDTH-1:0] e_dd  [4] = '{6'h15, 6'h3F, 6'h00, 6'h11};
        int unsigned        e_cnt [4] = '{3, 3, 2, 1};
        down_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++;
            if (down_valid !== 1'b1 || down_data !== e_dd[i] || count !== CW'(e_cnt[i]) ||
                up_ready !== 1'b1 || almost_full !== (e_cnt[i] >= AF_LEVEL)) begin
                n_fail++;
                $display("FAIL drain[%0d]: dv=%b dd=%h cnt=%0d ur=%b af=%b, required dd=%h cnt=%0d",
                         i, down_valid, down_data, count, up_ready, almost_full, e_dd[i], e_cnt[i]);
            end
            if (i == 1) up_valid = 1'b0;
        end
        tick();
        n_cmp++;
        if (down_valid !== 1'b0 || count !== 0) begin
            n_fail++;
            $display("FAIL drain_empty: dv=%b cnt=%0d, required 0 0", down_valid, count);
        end
    endtask

    task automatic test_random();
        int pushed = 0;
        int cycles = 0;
        int shown  = 0;
        while ((pushed < 2000 || m_q.size() > 0) && cycles < 30000) begin
            up_valid   = (pushed < 2000) && ($urandom_range(0, 99) < 65);
            up_data    = D_WIDTH'($urandom);
            down_ready = ($urandom_range(0, 99) < 55);
            if (up_valid && m_ur) pushed++;
            tick();
            cycles++;
            n_cmp++;
            if ($isunknown({down_valid, down_data, count, almost_full, up_ready}) ||
                down_valid !== (m_q.size() > 0) || count !== CW'(m_q.size()) ||
                count > DEPTH || up_ready !== m_ur ||
                almost_full !== (m_q.size() >= AF_LEVEL) ||
                (m_q.size() > 0 && down_data !== m_q[0])) begin
                n_fail++;
                if (shown < 10) begin
                    shown++;
                    $display("FAIL random@%0d: dv=%b dd=%h cnt=%0d ur=%b af=%b, required dv=%b dd=%h cnt=%0d ur=%b",
                             cycles, down_valid, down_data, count, up_ready, almost_full,
                             m_q.size() > 0, (m_q.size() > 0) ? m_q[0] : '0, m_q.size(), m_ur);
                end
            end
        end
        up_valid = 1'b0;
        n_cmp++;
        if (pushed < 2000 || m_q.size() != 0) begin
            n_fail++;
            $display("FAIL random_timeout: pushed=%0d held=%0d after %0d cycles, required 2000 0",
                     pushed, m_q.size(), cycles);
        end
    endtask

    task automatic test_mid_reset();
        down_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            up_valid = 1'b1;
            up_data  = D_WIDTH'(6'h30 + k);
            tick();
        end
        n_cmp++;
        if (count !== 3 || almost_full !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_pre: cnt=%0d af=%b, required 3 1", count, almost_full);
        end
        up_valid = 1'b0;
        rst = 1'b0;
        #1;
        n_cmp++;
        if (down_valid !== 1'b0 || count !== 0 || almost_full !== 1'b0 || up_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_async: dv=%b cnt=%0d af=%b ur=%b, required all 0",
                     down_valid, count, almost_full, up_ready);
        end
        tick();
        tick();
        rst = 1'b1;
        tick();
        down_ready = 1'b1;
        up_valid   = 1'b1;
        up_data    = 6'h05;
        tick();
        n_cmp++;
        if (down_valid !== 1'b1 || down_data !== 6'h05 || count !== 1) begin
            n_fail++;
            $display("FAIL midrst_w0: dv=%b dd=%h cnt=%0d, required 1 05 1", down_valid, down_data, count);
        end
        up_data = 6'h06;
        tick();
        n_cmp++;
        if (down_valid !== 1'b1 || down_data !== 6'h06 || count !== 1) begin
            n_fail++;
            $display("FAIL midrst_w1: dv=%b dd=%h cnt=%0d, required 1 06 1", down_valid, down_data, count);
        end
        up_valid = 1'b0;
        tick();
        n_cmp++;
        if (down_valid !== 1'b0 || count !== 0) begin
            n_fail++;
            $display("FAIL midrst_end: dv=%b cnt=%0d, required 0 0", down_valid, count);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_fill_stall();
        test_drain();
        test_random();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/elastic_fifo.md
Name: elastic_fifo

Overview:
Parametrised valid/ready elastic buffer. It is the successor of the single-slot upstream/downstream stage, generalised to DEPTH entries. It adds a registered output, occupancy reporting and an almost-full flag. It sits between any two valid/ready stages to absorb backpressure bursts without a combinational path from down_ready to up_ready.

Parameters:
D_WIDTH, 6, payload width in bits (>=1)
DEPTH, 4, total capacity in words including the output register; power of 2, >=2
AF_LEVEL, 3, almost_full asserts when count >= AF_LEVEL; legal range 1..DEPTH

Ports:
clk  in  1  single clock, all logic on rising edge
rst  in  1  reset, asynchronous, active-low (0 = reset)
up_valid  in  1  upstream word valid
up_ready  out  1  buffer can accept a word this cycle
up_data  in  D_WIDTH  upstream payload
down_valid  out  1  down_data holds a valid word
down_ready  in  1  downstream accepts this cycle
down_data  out  D_WIDTH  downstream payload, driven from a register
count  out  $clog2(DEPTH+1)  words held, output register included
almost_full  out  1  count >= AF_LEVEL

Behaviour:
- Reset (rst=0, asynchronous): state is cleared immediately, without waiting for a clock edge.
  - down_valid=0, down_data=0, count=0, almost_full=0, up_ready=0.
  - Read/write pointers = 0. Storage RAM contents are don't-care.
- Reset release: up_ready goes to 1 at the first rising clk edge with rst=1.
- up_ready is a register. It equals "count_next < DEPTH", evaluated at each edge. No combinational path exists from down_ready or up_valid to up_ready.
- Push: occurs when up_valid & up_ready at an edge.
- Pop: occurs when down_valid & down_ready at an edge.
- count update: count_next = count + push - pop. count saturates by construction; it never exceeds DEPTH or underflows.
- Structure: output register plus internal circular store of DEPTH-1 words.
  - Pointers are $clog2(DEPTH-1)-bit and wrap from DEPTH-2 to 0. Wrap without gaps and without loss is required.
- Latency: a word pushed at edge N into an empty buffer appears with down_valid=1 after edge N (visible in cycle N+1). Throughput is 1 word/cycle when neither side stalls.
- Output register refill, at every edge where the output register becomes or stays empty-after-pop:
  - Internal store non-empty: load the oldest stored word.
  - Store empty and push occurring: load up_data directly (bypass into the output register, still registered).
  - Otherwise: down_valid goes to 0.
- Ordering: strict FIFO. No duplication or drop under any valid/ready pattern.
- Data stability: down_valid=1 & down_ready=0 keeps down_valid and down_data unchanged at the next edge.
- Simultaneous push and pop:
  - When full, up_ready=0, so no push happens in the same cycle as the freeing pop. up_ready rises one cycle later.
  - When count=1 with both events, the new word moves to the output register and count stays 1.
- Empty: down_valid=0. down_data holds its last value; it is not required to be zero.
- almost_full: registered, consistent with count every cycle.
- Reset mid-operation: all contents discarded. Outputs are as listed under Reset within the same cycle as rst falling.
- up_data is sampled only on push. Values while up_valid=0 are ignored.

Test Plan:
1. Reset then idle. Hold rst=0 for 3 clks, release → up_ready=0 until the first edge after release, then 1; down_valid=0; count=0; almost_full=0.
2. Streaming, down_ready=1. Push 0x01..0x10 on consecutive cycles → down_data sequence 0x01..0x10, each one cycle after its push; count stays at 1; up_ready stays 1.
3. Fill and stall, down_ready=0. Push 0x2A,0x15,0x3F,0x00 → count goes 1,2,3,4; almost_full=1 from count=3; up_ready=0 after the 4th push; a 5th word 0x11 held on up_valid is not accepted; down_data=0x2A stays stable.
4. Drain from full. From scenario 3, raise down_ready → outputs 0x2A,0x15,0x3F,0x00 on consecutive cycles; up_ready rises the cycle after the first pop; then 0x11 is accepted and appears last.
5. Random valid/ready toggling, 2000 words, pointer wrap exercised many times → scoreboard order exact; count never >4; no X on outputs after reset.
6. Reset mid-burst. Assert rst with count=3 → down_valid, count and almost_full drop to 0 before the next clk edge; after release, new words 0x05,0x06 emerge with no stale data.
